multisim_server_axi_bridge: RTL and testbench
=============================================

Name: multisim_server_axi_bridge

Overview:
- Server-end counterpart of the AXI push client.
- Takes AW/W/AR beats arriving on multisim server pull channels and drives them onto an AXI manager port toward the real subordinate.
- Returns B/R responses toward multisim server push channels.
- Decouples each channel with a registered FIFO, caps in-flight write and read transactions, and flags response-without-request protocol errors.

Parameters:
- axi_aw_t, (none), AW payload struct type.
- axi_w_t, (none), W payload struct type.
- axi_b_t, (none), B payload struct type.
- axi_ar_t, (none), AR payload struct type.
- axi_r_t, (none), R payload struct type; must contain a 1-bit member named last.
- FIFO_DEPTH, 2, entries per channel FIFO; power of two, at least 2.
- MAX_OUTSTANDING, 4, maximum in-flight write transactions, and separately read transactions; at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_ch_aw, i_ch_aw_vld / o_ch_aw_rdy  in, in / out  $bits(axi_aw_t), 1 / 1  AW from server pull channel.
- i_ch_w, i_ch_w_vld / o_ch_w_rdy  in, in / out  $bits(axi_w_t), 1 / 1  W from server pull channel.
- i_ch_ar, i_ch_ar_vld / o_ch_ar_rdy  in, in / out  $bits(axi_ar_t), 1 / 1  AR from server pull channel.
- o_ch_b, o_ch_b_vld / i_ch_b_rdy  out, out / in  $bits(axi_b_t), 1 / 1  B to server push channel.
- o_ch_r, o_ch_r_vld / i_ch_r_rdy  out, out / in  $bits(axi_r_t), 1 / 1  R to server push channel.
- o_axi_m_aw, o_axi_m_awvalid / i_axi_m_awready  out, out / in  AW type, 1 / 1  AXI manager AW.
- o_axi_m_w, o_axi_m_wvalid / i_axi_m_wready  out, out / in  W type, 1 / 1  AXI manager W.
- i_axi_m_b, i_axi_m_bvalid / o_axi_m_bready  in, in / out  B type, 1 / 1  AXI manager B.
- o_axi_m_ar, o_axi_m_arvalid / i_axi_m_arready  out, out / in  AR type, 1 / 1  AXI manager AR.
- i_axi_m_r, i_axi_m_rvalid / o_axi_m_rready  in, in / out  R type, 1 / 1  AXI manager R.
- o_wr_outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight writes.
- o_rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight reads.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset, asynchronous while rst_n is low:
  - all five FIFOs empty, counters 0, o_err 0;
  - all valid outputs 0; all ready outputs 0 while rst_n is low, 1 in the first cycle after release.
- FIFOs:
  - Registered, no fall-through; ready = !full, valid = !empty, data = head entry.
  - Push when vld && rdy; pop when downstream valid && ready.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: occupancy unchanged, order preserved.
  - A push is refused when full, even if a pop occurs the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a beat accepted on a channel at cycle N is presented on the AXI side at cycle N+1 at the earliest; responses likewise take 1 cycle AXI→channel. Full throughput of 1 beat/cycle per channel when FIFO_DEPTH ≥ 2.
- Valid stability: once asserted, AXI valid outputs hold with stable payload until handshake (AXI rule); the FIFO head does not change while the output is stalled.
- Write gating:
  - o_axi_m_awvalid = aw_fifo_nonempty && (wr_cnt < MAX_OUTSTANDING).
  - wr_cnt +1 on AW handshake, −1 on B handshake; both in the same cycle: unchanged.
  - W is not gated; W may lead AW.
- Read gating:
  - o_axi_m_arvalid = ar_fifo_nonempty && (rd_cnt < MAX_OUTSTANDING).
  - rd_cnt +1 on AR handshake, −1 on R handshake with last=1; non-last R beats leave the counter unchanged.
- Response acceptance: o_axi_m_bready / o_axi_m_rready = !full of the B / R FIFO; there is no dependence on the counters.
- Error handling:
  - A B handshake while wr_cnt==0, or an R-last handshake while rd_cnt==0, leaves the counter at 0 (saturating) and sets o_err.
  - The response is still forwarded.
  - o_err clears only on reset.
- Counters never exceed MAX_OUTSTANDING; o_wr_outstanding and o_rd_outstanding are direct register outputs.

Test Plan:
- Single write: AW addr 0x100 then W data 0xDEAD on channels, awready/wready tied 1:
  - AXI AW and W appear 1 cycle after channel handshake;
  - o_wr_outstanding goes 0→1;
  - B okay returns, appears on o_ch_b 1 cycle later, and the counter returns to 0.
- Outstanding cap, MAX_OUTSTANDING=4: push 6 ARs, no R returned:
  - exactly 4 AR handshakes;
  - o_axi_m_arvalid stays 0 while the 5th is held;
  - one R with last=1 releases exactly one more AR.
- Burst read: AR len=3, R beats with last only on the 4th beat → o_rd_outstanding stays 1 through beats 1-3 and drops to 0 after beat 4; data order preserved.
- Backpressure: i_ch_r_rdy=0 with FIFO_DEPTH=2 → after 2 R beats, o_axi_m_rready=0 and the third beat is held; releasing rdy drains in order at 1 beat/cycle.
- Simultaneous events: AW handshake and B handshake in the same cycle at wr_cnt=2 → wr_cnt remains 2.
- Error and reset: unsolicited B at wr_cnt=0 → o_err=1, B forwarded, counter 0; asserting rst_n low mid-burst empties all FIFOs immediately and clears o_err and all valids.

Source files
------------

// File: rtl/multisim_server_axi_bridge.sv
// Server-side AXI bridge: channel beats are buffered per channel and driven onto an
// AXI manager port, responses are buffered back, and in-flight writes/reads are capped.

module multisim_server_axi_bridge_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  T     in_i,
  input  logic in_vld_i,
  output logic in_rdy_o,
  output T     out_o,
  output logic out_vld_o,
  input  logic out_rdy_i
);
  localparam int unsigned AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, empty, push, pop;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  // Ready is held low for as long as reset is asserted.
  assign in_rdy_o  = !full && rst_n;
  assign out_vld_o = !empty;
  assign out_o     = mem_q[rd_ptr_q];
  assign push      = in_vld_i && in_rdy_o;
  assign pop       = out_rdy_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_i;
  end
endmodule

module multisim_server_axi_bridge #(
  parameter type         axi_aw_t        = logic [31:0],
  parameter type         axi_w_t         = logic [31:0],
  parameter type         axi_b_t         = logic [1:0],
  parameter type         axi_ar_t        = logic [31:0],
  parameter type         axi_r_t         = struct packed { logic [31:0] data; logic last; },
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  axi_aw_t       i_ch_aw,
  input  logic          i_ch_aw_vld,
  output logic          o_ch_aw_rdy,
  input  axi_w_t        i_ch_w,
  input  logic          i_ch_w_vld,
  output logic          o_ch_w_rdy,
  input  axi_ar_t       i_ch_ar,
  input  logic          i_ch_ar_vld,
  output logic          o_ch_ar_rdy,
  output axi_b_t        o_ch_b,
  output logic          o_ch_b_vld,
  input  logic          i_ch_b_rdy,
  output axi_r_t        o_ch_r,
  output logic          o_ch_r_vld,
  input  logic          i_ch_r_rdy,
  output axi_aw_t       o_axi_m_aw,
  output logic          o_axi_m_awvalid,
  input  logic          i_axi_m_awready,
  output axi_w_t        o_axi_m_w,
  output logic          o_axi_m_wvalid,
  input  logic          i_axi_m_wready,
  input  axi_b_t        i_axi_m_b,
  input  logic          i_axi_m_bvalid,
  output logic          o_axi_m_bready,
  output axi_ar_t       o_axi_m_ar,
  output logic          o_axi_m_arvalid,
  input  logic          i_axi_m_arready,
  input  axi_r_t        i_axi_m_r,
  input  logic          i_axi_m_rvalid,
  output logic          o_axi_m_rready,
  output logic [CW-1:0] o_wr_outstanding,
  output logic [CW-1:0] o_rd_outstanding,
  output logic          o_err
);
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic          err_q, err_d;
  logic          aw_head_vld, ar_head_vld, wr_room, rd_room;
  logic          aw_hs, b_hs, ar_hs, r_last_hs;

  assign wr_room = (wr_cnt_q < CW'(MAX_OUTSTANDING));
  assign rd_room = (rd_cnt_q < CW'(MAX_OUTSTANDING));

  // The head of the AW/AR FIFO only pops when the cap allows it to be presented.
  multisim_server_axi_bridge_fifo #(.T(axi_aw_t), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk(clk), .rst_n(rst_n),
    .in_i(i_ch_aw), .in_vld_i(i_ch_aw_vld), .in_rdy_o(o_ch_aw_rdy),
    .out_o(o_axi_m_aw), .out_vld_o(aw_head_vld), .out_rdy_i(i_axi_m_awready && wr_room)
  );

  multisim_server_axi_bridge_fifo #(.T(axi_w_t), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk(clk), .rst_n(rst_n),
    .in_i(i_ch_w), .in_vld_i(i_ch_w_vld), .in_rdy_o(o_ch_w_rdy),
    .out_o(o_axi_m_w), .out_vld_o(o_axi_m_wvalid), .out_rdy_i(i_axi_m_wready)
  );

  multisim_server_axi_bridge_fifo #(.T(axi_ar_t), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
    .clk(clk), .rst_n(rst_n),
    .in_i(i_ch_ar), .in_vld_i(i_ch_ar_vld), .in_rdy_o(o_ch_ar_rdy),
    .out_o(o_axi_m_ar), .out_vld_o(ar_head_vld), .out_rdy_i(i_axi_m_arready && rd_room)
  );

  multisim_server_axi_bridge_fifo #(.T(axi_b_t), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk(clk), .rst_n(rst_n),
    .in_i(i_axi_m_b), .in_vld_i(i_axi_m_bvalid), .in_rdy_o(o_axi_m_bready),
    .out_o(o_ch_b), .out_vld_o(o_ch_b_vld), .out_rdy_i(i_ch_b_rdy)
  );

  multisim_server_axi_bridge_fifo #(.T(axi_r_t), .DEPTH(FIFO_DEPTH)) u_r_fifo (
    .clk(clk), .rst_n(rst_n),
    .in_i(i_axi_m_r), .in_vld_i(i_axi_m_rvalid), .in_rdy_o(o_axi_m_rready),
    .out_o(o_ch_r), .out_vld_o(o_ch_r_vld), .out_rdy_i(i_ch_r_rdy)
  );

  assign o_axi_m_awvalid = aw_head_vld && wr_room;
  assign o_axi_m_arvalid = ar_head_vld && rd_room;

  assign aw_hs     = o_axi_m_awvalid && i_axi_m_awready;
  assign b_hs      = i_axi_m_bvalid && o_axi_m_bready;
  assign ar_hs     = o_axi_m_arvalid && i_axi_m_arready;
  assign r_last_hs = i_axi_m_rvalid && o_axi_m_rready && i_axi_m_r.last;

  // A response with nothing in flight saturates at zero and raises the sticky error.
  always_comb begin
    err_d    = err_q;
    wr_cnt_d = wr_cnt_q + CW'(aw_hs) - CW'(b_hs && (wr_cnt_q != '0));
    rd_cnt_d = rd_cnt_q + CW'(ar_hs) - CW'(r_last_hs && (rd_cnt_q != '0));
    if ((b_hs && (wr_cnt_q == '0)) || (r_last_hs && (rd_cnt_q == '0))) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign o_wr_outstanding = wr_cnt_q;
  assign o_rd_outstanding = rd_cnt_q;
  assign o_err            = err_q;
endmodule

// File: tb/tb_multisim_server_axi_bridge.sv
// Directed and randomized checks of multisim_server_axi_bridge against queue-based expectations.

module tb_multisim_server_axi_bridge;
  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [31:0] data; logic last; } r_t;

  localparam int unsigned MAXO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  aw_t  i_ch_aw;  logic i_ch_aw_vld, o_ch_aw_rdy;
  w_t   i_ch_w;   logic i_ch_w_vld,  o_ch_w_rdy;
  ar_t  i_ch_ar;  logic i_ch_ar_vld, o_ch_ar_rdy;
  b_t   o_ch_b;   logic o_ch_b_vld,  i_ch_b_rdy;
  r_t   o_ch_r;   logic o_ch_r_vld,  i_ch_r_rdy;
  aw_t  o_axi_m_aw; logic o_axi_m_awvalid, i_axi_m_awready;
  w_t   o_axi_m_w;  logic o_axi_m_wvalid,  i_axi_m_wready;
  b_t   i_axi_m_b;  logic i_axi_m_bvalid,  o_axi_m_bready;
  ar_t  o_axi_m_ar; logic o_axi_m_arvalid, i_axi_m_arready;
  r_t   i_axi_m_r;  logic i_axi_m_rvalid,  o_axi_m_rready;
  logic [2:0] o_wr_outstanding, o_rd_outstanding;
  logic o_err;

  multisim_server_axi_bridge #(
    .axi_aw_t(aw_t), .axi_w_t(w_t), .axi_b_t(b_t), .axi_ar_t(ar_t), .axi_r_t(r_t),
    .FIFO_DEPTH(2), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ch_aw(i_ch_aw), .i_ch_aw_vld(i_ch_aw_vld), .o_ch_aw_rdy(o_ch_aw_rdy),
    .i_ch_w(i_ch_w), .i_ch_w_vld(i_ch_w_vld), .o_ch_w_rdy(o_ch_w_rdy),
    .i_ch_ar(i_ch_ar), .i_ch_ar_vld(i_ch_ar_vld), .o_ch_ar_rdy(o_ch_ar_rdy),
    .o_ch_b(o_ch_b), .o_ch_b_vld(o_ch_b_vld), .i_ch_b_rdy(i_ch_b_rdy),
    .o_ch_r(o_ch_r), .o_ch_r_vld(o_ch_r_vld), .i_ch_r_rdy(i_ch_r_rdy),
    .o_axi_m_aw(o_axi_m_aw), .o_axi_m_awvalid(o_axi_m_awvalid), .i_axi_m_awready(i_axi_m_awready),
    .o_axi_m_w(o_axi_m_w), .o_axi_m_wvalid(o_axi_m_wvalid), .i_axi_m_wready(i_axi_m_wready),
    .i_axi_m_b(i_axi_m_b), .i_axi_m_bvalid(i_axi_m_bvalid), .o_axi_m_bready(o_axi_m_bready),
    .o_axi_m_ar(o_axi_m_ar), .o_axi_m_arvalid(o_axi_m_arvalid), .i_axi_m_arready(i_axi_m_arready),
    .i_axi_m_r(i_axi_m_r), .i_axi_m_rvalid(i_axi_m_rvalid), .o_axi_m_rready(o_axi_m_rready),
    .o_wr_outstanding(o_wr_outstanding), .o_rd_outstanding(o_rd_outstanding), .o_err(o_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hs, pushed, ar_tot, r_done, beats_left;
  logic [31:0] bd [4];
  logic [31:0] ar_exp [$];
  r_t          r_exp  [$];
  logic        ch_ar_hs, r_hs;
  logic [63:0] exp_v;

  initial begin
    rst_n = 1'b0;
    i_ch_aw = '0; i_ch_aw_vld = 1'b0; i_ch_w = '0; i_ch_w_vld = 1'b0;
    i_ch_ar = '0; i_ch_ar_vld = 1'b0; i_ch_b_rdy = 1'b1; i_ch_r_rdy = 1'b1;
    i_axi_m_awready = 1'b0; i_axi_m_wready = 1'b0; i_axi_m_arready = 1'b0;
    i_axi_m_b = '0; i_axi_m_bvalid = 1'b0; i_axi_m_r = '0; i_axi_m_rvalid = 1'b0;
    #2;
    check("rst_aw_rdy", 64'(o_ch_aw_rdy), 64'(0));
    check("rst_bready", 64'(o_axi_m_bready), 64'(0));
    check("rst_rready", 64'(o_axi_m_rready), 64'(0));
    check("rst_awvalid", 64'(o_axi_m_awvalid), 64'(0));
    check("rst_chb_vld", 64'(o_ch_b_vld), 64'(0));
    check("rst_wr_out", 64'(o_wr_outstanding), 64'(0));
    check("rst_rd_out", 64'(o_rd_outstanding), 64'(0));
    check("rst_err", 64'(o_err), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rel_aw_rdy", 64'(o_ch_aw_rdy), 64'(1));
    check("rel_w_rdy", 64'(o_ch_w_rdy), 64'(1));
    check("rel_ar_rdy", 64'(o_ch_ar_rdy), 64'(1));
    check("rel_bready", 64'(o_axi_m_bready), 64'(1));
    check("rel_rready", 64'(o_axi_m_rready), 64'(1));

    // Single write
    i_axi_m_awready = 1'b1; i_axi_m_wready = 1'b1;
    i_ch_aw = '{addr: 32'h100, len: 8'd0}; i_ch_aw_vld = 1'b1;
    #1 check("wr_aw_not_early", 64'(o_axi_m_awvalid), 64'(0));
    tick();
    check("wr_awvalid", 64'(o_axi_m_awvalid), 64'(1));
    check("wr_aw_addr", 64'(o_axi_m_aw.addr), 64'h100);
    check("wr_cnt_pre", 64'(o_wr_outstanding), 64'(0));
    i_ch_aw_vld = 1'b0; i_ch_w = '{data: 32'hDEAD, last: 1'b1}; i_ch_w_vld = 1'b1;
    tick();
    check("wr_cnt_1", 64'(o_wr_outstanding), 64'(1));
    check("wr_aw_done", 64'(o_axi_m_awvalid), 64'(0));
    check("wr_wvalid", 64'(o_axi_m_wvalid), 64'(1));
    check("wr_w_data", 64'(o_axi_m_w.data), 64'hDEAD);
    i_ch_w_vld = 1'b0;
    tick();
    check("wr_w_done", 64'(o_axi_m_wvalid), 64'(0));
    i_axi_m_b = '{id: 4'h5, resp: 2'b00}; i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
    check("wr_b_fwd_vld", 64'(o_ch_b_vld), 64'(1));
    check("wr_b_fwd", 64'(o_ch_b), 64'({4'h5, 2'b00}));
    check("wr_cnt_0", 64'(o_wr_outstanding), 64'(0));
    tick();
    check("wr_b_drained", 64'(o_ch_b_vld), 64'(0));
    check("wr_err", 64'(o_err), 64'(0));

    // Outstanding read cap: six ARs, no responses
    i_axi_m_arready = 1'b1; hs = 0; pushed = 0;
    for (int i = 0; i < 16; i++) begin
      i_ch_ar_vld = (pushed < 6);
      i_ch_ar = '{addr: 32'h300 + 32'(pushed), len: 8'd0};
      #1;
      if (i_ch_ar_vld && o_ch_ar_rdy) pushed++;
      if (o_axi_m_arvalid && i_axi_m_arready) begin
        check("cap_ar_order", 64'(o_axi_m_ar.addr), 64'(32'h300 + 32'(hs)));
        hs++;
      end
      tick();
    end
    i_ch_ar_vld = 1'b0;
    check("cap_hs", 64'(hs), 64'(4));
    check("cap_pushed", 64'(pushed), 64'(6));
    check("cap_rd_out", 64'(o_rd_outstanding), 64'(4));
    check("cap_arvalid_held", 64'(o_axi_m_arvalid), 64'(0));
    check("cap_ch_full", 64'(o_ch_ar_rdy), 64'(0));
    i_axi_m_r = '{data: 32'h1111, last: 1'b1}; i_axi_m_rvalid = 1'b1;
    tick();
    i_axi_m_rvalid = 1'b0;
    check("cap_rd_3", 64'(o_rd_outstanding), 64'(3));
    check("cap_release", 64'(o_axi_m_arvalid), 64'(1));
    check("cap_release_addr", 64'(o_axi_m_ar.addr), 64'h304);
    tick();
    check("cap_rd_4_again", 64'(o_rd_outstanding), 64'(4));
    repeat (3) tick();
    check("cap_one_more_only", 64'(o_axi_m_arvalid), 64'(0));
    for (int k = 0; k < 5; k++) begin
      i_axi_m_r = '{data: $urandom, last: 1'b1}; i_axi_m_rvalid = 1'b1;
      tick();
    end
    i_axi_m_rvalid = 1'b0;
    repeat (3) tick();
    check("cap_drained_rd", 64'(o_rd_outstanding), 64'(0));
    check("cap_drained_ar", 64'(o_axi_m_arvalid), 64'(0));
    check("cap_err", 64'(o_err), 64'(0));

    // Burst read, last on the fourth beat
    i_ch_ar = '{addr: 32'h200, len: 8'd3}; i_ch_ar_vld = 1'b1;
    tick();
    i_ch_ar_vld = 1'b0;
    check("burst_arvalid", 64'(o_axi_m_arvalid), 64'(1));
    check("burst_ar", 64'(o_axi_m_ar), 64'({32'h200, 8'd3}));
    tick();
    check("burst_rd_1", 64'(o_rd_outstanding), 64'(1));
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      i_axi_m_r = '{data: bd[i], last: (i == 3)}; i_axi_m_rvalid = 1'b1;
      tick();
      check("burst_rd_cnt", 64'(o_rd_outstanding), 64'((i == 3) ? 0 : 1));
      check("burst_ch_r", 64'(o_ch_r), 64'({bd[i], (i == 3)}));
    end
    i_axi_m_rvalid = 1'b0;
    tick();
    check("burst_drained", 64'(o_ch_r_vld), 64'(0));

    // R backpressure with a two-entry FIFO
    i_ch_r_rdy = 1'b0;
    for (int i = 0; i < 3; i++) bd[i] = $urandom;
    i_axi_m_r = '{data: bd[0], last: 1'b0}; i_axi_m_rvalid = 1'b1;
    tick();
    i_axi_m_r = '{data: bd[1], last: 1'b0};
    tick();
    check("bp_rready_low", 64'(o_axi_m_rready), 64'(0));
    i_axi_m_r = '{data: bd[2], last: 1'b0};
    repeat (2) tick();
    check("bp_still_low", 64'(o_axi_m_rready), 64'(0));
    check("bp_head", 64'(o_ch_r.data), 64'(bd[0]));
    check("bp_rd_cnt", 64'(o_rd_outstanding), 64'(0));
    i_ch_r_rdy = 1'b1;
    tick();
    check("bp_drain1", 64'(o_ch_r.data), 64'(bd[1]));
    check("bp_rready_back", 64'(o_axi_m_rready), 64'(1));
    tick();
    i_axi_m_rvalid = 1'b0;
    check("bp_drain2_vld", 64'(o_ch_r_vld), 64'(1));
    check("bp_drain2", 64'(o_ch_r.data), 64'(bd[2]));
    tick();
    check("bp_empty", 64'(o_ch_r_vld), 64'(0));
    check("bp_err", 64'(o_err), 64'(0));

    // AW and B handshakes in the same cycle at wr_cnt=2
    i_ch_aw = '{addr: 32'h400, len: 8'd0}; i_ch_aw_vld = 1'b1;
    tick();
    i_ch_aw = '{addr: 32'h401, len: 8'd0};
    tick();
    i_ch_aw_vld = 1'b0;
    tick();
    check("sim_cnt_2", 64'(o_wr_outstanding), 64'(2));
    i_ch_aw = '{addr: 32'h402, len: 8'd0}; i_ch_aw_vld = 1'b1;
    tick();
    i_ch_aw_vld = 1'b0;
    check("sim_awvalid", 64'(o_axi_m_awvalid), 64'(1));
    i_axi_m_b = '{id: 4'h1, resp: 2'b00}; i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
    check("sim_cnt_hold", 64'(o_wr_outstanding), 64'(2));
    check("sim_aw_taken", 64'(o_axi_m_awvalid), 64'(0));
    i_axi_m_bvalid = 1'b1;
    repeat (2) tick();
    i_axi_m_bvalid = 1'b0;
    check("sim_cnt_0", 64'(o_wr_outstanding), 64'(0));
    check("sim_err", 64'(o_err), 64'(0));
    tick();

    // Unsolicited B
    i_axi_m_b = '{id: 4'h9, resp: 2'b10}; i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
    check("err_set", 64'(o_err), 64'(1));
    check("err_cnt_sat", 64'(o_wr_outstanding), 64'(0));
    check("err_b_fwd_vld", 64'(o_ch_b_vld), 64'(1));
    check("err_b_fwd", 64'(o_ch_b), 64'({4'h9, 2'b10}));
    repeat (2) tick();
    check("err_sticky", 64'(o_err), 64'(1));

    // Reset asserted with data parked in FIFOs
    i_axi_m_awready = 1'b0; i_ch_r_rdy = 1'b0;
    i_ch_aw = '{addr: 32'h500, len: 8'd0}; i_ch_aw_vld = 1'b1;
    i_axi_m_r = '{data: 32'h77, last: 1'b0}; i_axi_m_rvalid = 1'b1;
    repeat (2) tick();
    i_ch_aw_vld = 1'b0; i_axi_m_rvalid = 1'b0;
    check("mid_awvalid", 64'(o_axi_m_awvalid), 64'(1));
    check("mid_chr_vld", 64'(o_ch_r_vld), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", 64'(o_axi_m_awvalid), 64'(0));
    check("mid_rst_chr_vld", 64'(o_ch_r_vld), 64'(0));
    check("mid_rst_chb_vld", 64'(o_ch_b_vld), 64'(0));
    check("mid_rst_err", 64'(o_err), 64'(0));
    check("mid_rst_aw_rdy", 64'(o_ch_aw_rdy), 64'(0));
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_awvalid", 64'(o_axi_m_awvalid), 64'(0));
    check("post_rst_chr_vld", 64'(o_ch_r_vld), 64'(0));
    check("post_rst_aw_rdy", 64'(o_ch_aw_rdy), 64'(1));
    check("post_rst_rready", 64'(o_axi_m_rready), 64'(1));
    tick();

    // Randomized read traffic against a queue model
    ar_tot = 0; r_done = 0; beats_left = 0;
    for (int cyc = 0; cyc < 480; cyc++) begin
      automatic logic drain = (cyc >= 400);
      if (!drain && !i_ch_ar_vld && ($urandom % 2 == 0)) begin
        i_ch_ar_vld = 1'b1;
        i_ch_ar = '{addr: $urandom, len: 8'd0};
      end
      i_axi_m_arready = drain ? 1'b1 : ($urandom % 4 != 0);
      i_ch_r_rdy      = drain ? 1'b1 : ($urandom % 2 == 0);
      if (!i_axi_m_rvalid && (ar_tot > r_done) && (drain || ($urandom % 2 == 0))) begin
        beats_left = $urandom_range(1, 3);
        i_axi_m_rvalid = 1'b1;
        i_axi_m_r = '{data: $urandom, last: (beats_left == 1)};
      end
      #1;
      check("rnd_rd_out", 64'(o_rd_outstanding), 64'(ar_tot - r_done));
      if (o_rd_outstanding == 3'(MAXO)) check("rnd_cap_gate", 64'(o_axi_m_arvalid), 64'(0));
      ch_ar_hs = i_ch_ar_vld && o_ch_ar_rdy;
      if (ch_ar_hs) ar_exp.push_back(i_ch_ar.addr);
      if (o_axi_m_arvalid && i_axi_m_arready) begin
        exp_v = (ar_exp.size() > 0) ? 64'(ar_exp.pop_front()) : 64'hDEAD_0000_0000_0000;
        check("rnd_ar_order", 64'(o_axi_m_ar.addr), exp_v);
        ar_tot++;
      end
      r_hs = i_axi_m_rvalid && o_axi_m_rready;
      if (r_hs) r_exp.push_back(i_axi_m_r);
      if (o_ch_r_vld && i_ch_r_rdy) begin
        exp_v = (r_exp.size() > 0) ? 64'(r_exp.pop_front()) : 64'hDEAD_0000_0000_0000;
        check("rnd_r_order", 64'(o_ch_r), exp_v);
      end
      tick();
      if (ch_ar_hs) i_ch_ar_vld = 1'b0;
      if (r_hs) begin
        if (i_axi_m_r.last) begin
          r_done++;
          i_axi_m_rvalid = 1'b0;
        end else begin
          beats_left--;
          i_axi_m_r = '{data: $urandom, last: (beats_left == 1)};
        end
      end
    end
    check("rnd_ar_q_empty", 64'(ar_exp.size()), 64'(0));
    check("rnd_r_q_empty", 64'(r_exp.size()), 64'(0));
    check("rnd_rd_final", 64'(o_rd_outstanding), 64'(0));
    check("rnd_err", 64'(o_err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
